// File: rtl/local_frame_ctrl.sv
// Local-variable frame controller: GET/SET through fp+index and ENTER/LEAVE frame push/pop.
// Optional macro LOCAL_BOUNDS_CHECK_EN traps GET/SET whose index is outside the current frame.
module local_frame_ctrl #(
    parameter int unsigned STACK_DEPTH = 7,
    parameter int unsigned FRAME_ADDR  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [7:0]           req_index,
    input  logic [63:0]          set_data,
    input  logic [1:0]           set_type,
    input  logic [STACK_DEPTH:0] sp,
    output logic [STACK_DEPTH:0] mem_addr,
    output logic                 mem_we,
    output logic [63:0]          mem_wdata,
    output logic [1:0]           mem_wtype,
    input  logic [63:0]          mem_rdata,
    input  logic [1:0]           mem_rtype,
    output logic                 resp_valid,
    output logic [63:0]          resp_data,
    output logic [1:0]           resp_type,
    output logic [STACK_DEPTH:0] fp,
    output logic [3:0]           trap
);
    localparam int unsigned AW = STACK_DEPTH + 1;
    localparam int unsigned FD = 1 << FRAME_ADDR;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, RESP, TRAP} state_t;
    typedef enum logic [1:0] {OP_GET, OP_SET, OP_ENTER, OP_LEAVE} op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d, op_in;
    logic [AW-1:0]       fp_q, fp_d, addr_q, addr_d;
    logic [7:0]          nl_q, nl_d;
    logic [FRAME_ADDR:0] depth_q, depth_d;
    logic [3:0]          trap_q, trap_d, trap_code;
    logic                we_q, we_d;
    logic [63:0]         wdata_q, wdata_d, rd_q, rd_d, resp_data_q, resp_data_d;
    logic [1:0]          wtype_q, wtype_d, rt_q, rt_d, resp_type_q, resp_type_d;
    logic                resp_valid_q, resp_valid_d;
    logic                hs, push, pop;
    logic [FRAME_ADDR-1:0] top_idx;

    logic [AW-1:0] stk_fp [FD];
    logic [7:0]    stk_nl [FD];

    assign top_idx = FRAME_ADDR'(depth_q - 1'b1);

    always_comb begin
        op_in     = op_t'(req_op);
        hs        = req_valid && (state_q == IDLE);
        trap_code = '0;
        if (hs) begin
            unique case (op_in)
                OP_GET, OP_SET: begin
`ifdef LOCAL_BOUNDS_CHECK_EN
                    if (req_index >= nl_q) trap_code = 4'd2;
`endif
                end
                OP_ENTER: begin
                    if (32'(req_index) > 32'(sp)) trap_code = 4'd1;
                    else if (depth_q[FRAME_ADDR]) trap_code = 4'd3;
                end
                OP_LEAVE: begin
                    if (depth_q == '0) trap_code = 4'd4;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fp_d         = fp_q;
        nl_d         = nl_q;
        depth_d      = depth_q;
        trap_d       = trap_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        wtype_d      = wtype_q;
        rd_d         = rd_q;
        rt_d         = rt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_type_d  = resp_type_q;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    op_d = op_in;
                    if (trap_code != '0) begin
                        trap_d  = trap_code;
                        state_d = TRAP;
                    end else begin
                        unique case (op_in)
                            OP_GET: begin
                                addr_d  = fp_q + AW'(req_index);
                                state_d = ADDR;
                            end
                            OP_SET: begin
                                addr_d  = fp_q + AW'(req_index);
                                we_d    = 1'b1;
                                wdata_d = set_data;
                                wtype_d = set_type;
                                state_d = ADDR;
                            end
                            OP_ENTER: begin
                                push    = 1'b1;
                                fp_d    = sp - AW'(req_index);
                                nl_d    = req_index;
                                depth_d = depth_q + 1'b1;
                                state_d = RESP;
                            end
                            OP_LEAVE: begin
                                pop     = 1'b1;
                                fp_d    = stk_fp[top_idx];
                                nl_d    = stk_nl[top_idx];
                                depth_d = depth_q - 1'b1;
                                state_d = RESP;
                            end
                        endcase
                    end
                end
            end
            ADDR: state_d = (op_q == OP_GET) ? WAIT : RESP;
            WAIT: begin
                rd_d    = mem_rdata;
                rt_d    = mem_rtype;
                state_d = RESP;
            end
            // Result moves to the outputs together with the pulse so resp_data never changes while idle.
            RESP: begin
                resp_valid_d = 1'b1;
                if (op_q == OP_GET) begin
                    resp_data_d = rd_q;
                    resp_type_d = rt_q;
                end
                state_d = IDLE;
            end
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= OP_GET;
            fp_q         <= '0;
            nl_q         <= '0;
            depth_q      <= '0;
            trap_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wtype_q      <= '0;
            rd_q         <= '0;
            rt_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_type_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            fp_q         <= fp_d;
            nl_q         <= nl_d;
            depth_q      <= depth_d;
            trap_q       <= trap_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wtype_q      <= wtype_d;
            rd_q         <= rd_d;
            rt_q         <= rt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_type_q  <= resp_type_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            stk_fp[depth_q[FRAME_ADDR-1:0]] <= fp_q;
            stk_nl[depth_q[FRAME_ADDR-1:0]] <= nl_q;
        end
    end

    assign req_ready  = (state_q == IDLE);
    // Reset during SET's ADDR cycle must suppress the pending RAM write at that same edge.
    assign mem_we     = we_q && reset;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wtype  = wtype_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_type  = resp_type_q;
    assign fp         = fp_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_local_frame_ctrl.sv
// Self-checking bench for local_frame_ctrl: directed and random requests against a queue-based frame model.
module tb_local_frame_ctrl;
    localparam int FD = 16;
    localparam logic [1:0] T_I64 = 2'd1;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, mem_we, resp_valid;
    logic [1:0]  req_op, set_type, mem_wtype, mem_rtype, resp_type;
    logic [7:0]  req_index, sp, mem_addr, fp;
    logic [63:0] set_data, mem_wdata, mem_rdata, resp_data;
    logic [3:0]  trap;

    always #5 clk = ~clk;

    local_frame_ctrl #(.STACK_DEPTH(7), .FRAME_ADDR(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_index(req_index), .set_data(set_data), .set_type(set_type),
        .sp(sp), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_wtype(mem_wtype), .mem_rdata(mem_rdata), .mem_rtype(mem_rtype),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_type(resp_type),
        .fp(fp), .trap(trap)
    );

    // Stack RAM with one-cycle read latency and a preload port
    logic [63:0] ram  [256];
    logic [1:0]  ramt [256];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [63:0] pl_d;
    logic [1:0]  pl_t;
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_a]  <= pl_d;
            ramt[pl_a] <= pl_t;
        end else if (mem_we) begin
            ram[mem_addr]  <= mem_wdata;
            ramt[mem_addr] <= mem_wtype;
        end
        mem_rdata <= ram[mem_addr];
        mem_rtype <= ramt[mem_addr];
    end

    // Reference model
    logic [63:0] m_ram [256];
    logic [1:0]  m_rt  [256];
    int          m_fp, m_nl;
    int          fq_fp[$], fq_nl[$];
    logic [63:0] m_last_data;
    logic [1:0]  m_last_type;

    int n_cmp = 0;
    int n_err = 0;

    int          o_lat, o_pulses, o_we_cnt;
    logic [7:0]  o_addr0;
    logic [63:0] o_wd0, o_rdata;
    logic [1:0]  o_wt0, o_rtype;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fp = 0;
        m_nl = 0;
        fq_fp.delete();
        fq_nl.delete();
        m_last_data = '0;
        m_last_type = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rv"}, resp_valid, 0);
        chk({tag, "_rdata"}, resp_data, 0);
        chk({tag, "_rtype"}, resp_type, 0);
        chk({tag, "_fp"}, fp, 0);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic model(input logic [1:0] op, input int idx, input int spv,
                         input logic [63:0] d, input logic [1:0] t,
                         output int e_trap, output int e_lat, output int e_addr);
        e_trap = 0;
        e_lat  = -1;
        e_addr = (m_fp + idx) % 256;
        case (op)
            2'd0, 2'd1: begin
`ifdef LOCAL_BOUNDS_CHECK_EN
                if (idx >= m_nl) e_trap = 2;
`endif
            end
            2'd2: if (idx > spv) e_trap = 1; else if (fq_fp.size() == FD) e_trap = 3;
            default: if (fq_fp.size() == 0) e_trap = 4;
        endcase
        if (e_trap != 0) return;
        case (op)
            2'd0: begin
                m_last_data = m_ram[e_addr];
                m_last_type = m_rt[e_addr];
                e_lat = 3;
            end
            2'd1: begin
                m_ram[e_addr] = d;
                m_rt[e_addr]  = t;
                e_lat = 2;
            end
            2'd2: begin
                fq_fp.push_back(m_fp);
                fq_nl.push_back(m_nl);
                m_fp = (spv - idx) % 256;
                m_nl = idx;
                e_lat = 1;
            end
            default: begin
                m_fp = fq_fp.pop_back();
                m_nl = fq_nl.pop_back();
                e_lat = 1;
            end
        endcase
    endtask

    // One handshake, then six sampled cycles (after handshake edge and five more)
    task automatic req(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] spv,
                       input logic [63:0] d, input logic [1:0] t);
        req_op = op; req_index = idx; sp = spv; set_data = d; set_type = t;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_index = 8'($urandom);
        sp = 8'($urandom);
        set_data = ~d;
        set_type = ~t;
        o_addr0 = mem_addr;
        o_wd0 = mem_wdata;
        o_wt0 = mem_wtype;
        o_lat = -1;
        o_pulses = 0;
        o_we_cnt = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            if (mem_we) o_we_cnt++;
            if (resp_valid) begin
                o_pulses++;
                if (o_lat < 0) begin
                    o_lat = c;
                    o_rdata = resp_data;
                    o_rtype = resp_type;
                end
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [7:0] idx,
                       input logic [7:0] spv, input logic [63:0] d, input logic [1:0] t);
        int e_trap, e_lat, e_addr;
        chk({tag, "_ready"}, req_ready, 1);
        model(op, int'(idx), int'(spv), d, t, e_trap, e_lat, e_addr);
        req(op, idx, spv, d, t);
        chk({tag, "_trap"}, trap, e_trap);
        chk({tag, "_lat"}, o_lat, e_lat);
        chk({tag, "_pulses"}, o_pulses, (e_trap == 0) ? 1 : 0);
        chk({tag, "_fp"}, fp, m_fp);
        chk({tag, "_wecnt"}, o_we_cnt, (e_trap == 0 && op == 2'd1) ? 1 : 0);
        if (e_trap == 0 && op <= 2'd1) chk({tag, "_addr"}, o_addr0, e_addr);
        if (e_trap == 0 && op == 2'd1) begin
            chk({tag, "_wdata"}, o_wd0, d);
            chk({tag, "_wtype"}, o_wt0, t);
        end
        if (e_trap == 0 && op == 2'd0) begin
            chk({tag, "_data"}, o_rdata, m_last_data);
            chk({tag, "_type"}, o_rtype, m_last_type);
        end
        chk({tag, "_hold"}, resp_data, m_last_data);
        chk({tag, "_holdt"}, resp_type, m_last_type);
        if (e_trap != 0) chk({tag, "_ready_trap"}, req_ready, 0);
    endtask

    int          choice, npulse;
    logic [7:0]  spv, idx;
    logic [63:0] rv;
    logic [1:0]  rt;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = '0; req_index = '0;
        set_data = '0; set_type = '0; sp = '0;
        pl_en = 1'b1; pl_a = '0; pl_d = '0; pl_t = '0;
        model_reset();
        for (int a = 0; a < 256; a++) begin
            rv = {$urandom, $urandom};
            rt = 2'($urandom_range(0, 3));
            if (a == 4) begin
                rv = 64'd2;
                rt = T_I64;
            end
            pl_a = 8'(a); pl_d = rv; pl_t = rt;
            m_ram[a] = rv;
            m_rt[a]  = rt;
            tick();
        end
        pl_en = 1'b0;
        tick();
        chk_reset_state("reset0");
        reset = 1'b1;

        // Directed: first frame, GET, SET then GET back
        run("enter_2_5", 2'd2, 8'd2, 8'd5, '0, '0);
        chk("enter_fp3", fp, 3);
        run("get_1", 2'd0, 8'd1, 8'd0, '0, '0);
        chk("get_1_addr4", o_addr0, 4);
        chk("get_1_val2", o_rdata, 2);
        chk("get_1_i64", o_rtype, T_I64);
        run("set_0", 2'd1, 8'd0, 8'd0, 64'h55, 2'd2);
        chk("set_0_addr3", o_addr0, 3);
        run("get_0", 2'd0, 8'd0, 8'd0, '0, '0);
        chk("get_0_55", o_rdata, 64'h55);

        // Random legal traffic
        for (int k = 0; k < 80; k++) begin
            choice = int'($urandom_range(0, 3));
            if (m_nl == 0 && choice < 2) choice = 2;
            if (choice == 2 && fq_fp.size() == FD) choice = 3;
            if (choice == 3 && fq_fp.size() == 0) choice = 2;
            spv = 8'($urandom);
            if (choice == 2) idx = 8'($urandom_range(0, (spv < 10) ? int'(spv) : 10));
            else if (choice < 2) idx = 8'($urandom_range(0, m_nl - 1));
            else idx = 8'($urandom);
            run($sformatf("rnd%0d", k), 2'(choice), idx, spv, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end

        // Bounds check on local index
        do_reset();
        run("bc_enter", 2'd2, 8'd2, 8'd10, '0, '0);
        run("bc_get2", 2'd0, 8'd2, 8'd0, '0, '0);
`ifdef LOCAL_BOUNDS_CHECK_EN
        chk("bc_trap2", trap, 2);
`else
        chk("bc_addr10", o_addr0, 10);
`endif

        // LEAVE on empty frame stack traps and is absorbing
        do_reset();
        run("leave_empty", 2'd3, 8'd0, 8'd0, '0, '0);
        npulse = 0;
        req_op = 2'd2; req_index = 8'd0; sp = 8'd9; req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (resp_valid) npulse++;
            chk($sformatf("trap_abs_ready%0d", c), req_ready, 0);
            chk($sformatf("trap_abs_code%0d", c), trap, 4);
        end
        req_valid = 1'b0;
        chk("trap_abs_pulses", npulse, 0);
        do_reset();
        chk_reset_state("post_trap");

        // ENTER index boundary against sp
        run("enter_eq_sp", 2'd2, 8'd5, 8'd5, '0, '0);
        do_reset();
        run("enter_gt_sp", 2'd2, 8'd6, 8'd5, '0, '0);
        chk("enter_gt_sp_code", trap, 1);
        do_reset();

        // Fill the frame stack, unwind it, refill and overflow
        for (int k = 0; k < FD; k++) run($sformatf("fill%0d", k), 2'd2, 8'd1, 8'(k * 3 + 5), '0, '0);
        for (int k = 0; k < FD; k++) run($sformatf("unwind%0d", k), 2'd3, 8'd0, 8'd0, '0, '0);
        chk("unwind_to_reset_fp", fp, 0);
        for (int k = 0; k < FD; k++) run($sformatf("refill%0d", k), 2'd2, 8'd2, 8'(k * 7 + 20), '0, '0);
        run("overflow", 2'd2, 8'd0, 8'd50, '0, '0);
        chk("overflow_code", trap, 3);
        do_reset();

        // Reset during GET's WAIT cycle
        run("rg_enter", 2'd2, 8'd2, 8'd5, '0, '0);
        req_op = 2'd0; req_index = 8'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        npulse = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (resp_valid) npulse++;
        end
        chk("rst_wait_pulses", npulse, 0);
        chk("rst_wait_ready", req_ready, 1);
        chk("rst_wait_fp", fp, 0);

        // Reset during SET's ADDR cycle
        run("rs_enter", 2'd2, 8'd2, 8'd5, '0, '0);
        req_op = 2'd1; req_index = 8'd0; set_data = 64'hAA; set_type = 2'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_addr_we", mem_we, 0);
        tick();
        reset = 1'b1;
        model_reset();
        npulse = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (resp_valid) npulse++;
        end
        chk("rst_addr_pulses", npulse, 0);
        chk("rst_addr_ram", ram[3], m_ram[3]);
        chk("rst_addr_ready", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
